prio_arb_encoder: RTL and testbench
===================================

Name: prio_arb_encoder

Overview:
Parametrised, registered N-to-log2(N) priority encoder with selectable fixed-priority or round-robin arbitration. Each result is held on a valid/ready output until the consumer accepts it. It is the next generation of the team's 8-3 priority encoder: generalised width, an enable, a mode select, a one-hot grant, and back-pressure. It sits between raw request lines and a downstream consumer that services one index at a time.

Parameters:
N, 8, number of request inputs (N >= 2, power of two).
IDX_W, $clog2(N), width of the encoded index (derived; not overridden).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
en  input  1  arbitration enable; no new result is captured while low.
mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
req  input  N  request vector; bit i = request i.
out_ready  input  1  consumer accepts the held result when high with out_valid.
out_valid  output  1  held result is valid.
out_idx  output  IDX_W  encoded winning index.
out_grant  output  N  one-hot of out_idx; all zero when out_valid=0.
out_multi  output  1  more than one req bit was set at capture.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_idx=0, out_grant=0, out_multi=0, state=IDLE, rr_ptr=0. Outputs clear immediately, without waiting for a clock edge.
- States:
  - IDLE: out_valid=0.
  - HOLD: out_valid=1, all outputs frozen.
- Capture condition: cap = en && |req && (state==IDLE || out_ready).
- Latency: a capture at edge t makes the result visible after edge t; one cycle from req to out_valid.
- IDLE -> HOLD on cap. Otherwise stay in IDLE.
- HOLD with out_ready=0: stay in HOLD. Outputs do not change even if req, en or mode change.
- HOLD with out_ready=1: the result is accepted.
  - If cap also holds, load the new winner in the same edge and stay in HOLD (back-to-back, one result per cycle).
  - Otherwise go to IDLE.
- Fixed mode: the winner is the highest set index.
- Round-robin mode:
  - Search order is rr_ptr-1, rr_ptr-2, ... descending, wrapping modulo N, with rr_ptr itself searched last.
  - rr_ptr updates to the winning index at capture, in RR mode only.
  - With rr_ptr=0 after reset, RR order equals fixed order.
- Fixed-mode captures leave rr_ptr unchanged.
- mode and en are sampled only at capture.
- out_multi = popcount(req) > 1 at capture; held with the result.
- req=0 or en=0 at a would-be capture: no capture. From HOLD with out_ready=1 this means return to IDLE.
- No X-propagation on out_idx: it holds its last value when out_valid=0, and is 0 after reset.

Decomposition:
- Shared package prio_arb_pkg holds:
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - State enum {ST_IDLE, ST_HOLD}.
  - Function clog2 for tools lacking $clog2.
- Sub-module prio_enc_rot is purely combinational. Inputs: req[N], start[IDX_W]. Outputs: idx, found, multi.
  - It performs the descending wrapped search beginning at start-1.
  - The top level passes start=0 in fixed mode and start=rr_ptr in RR mode.
- The top level owns the state register, rr_ptr and the output registers.

Test Plan:
All scenarios use N=8.
1. Reset: assert rst_n=0 mid-simulation with no clock edge -> out_valid=0, out_idx=0, out_grant=8'h00, out_multi=0 immediately.
2. Fixed mode, en=1, req=8'b0010_1100, out_ready=1 -> next cycle out_valid=1, out_idx=5, out_grant=8'b0010_0000, out_multi=1. Then req=8'h00 -> out_valid=0 the following cycle.
3. Enable gating: en=0, req=8'hFF for 10 cycles -> out_valid stays 0. Set en=1 -> out_idx=7 after one edge.
4. Back-pressure: fixed mode, result idx=5 held with out_ready=0, then req changes to 8'h80 for 4 cycles -> out_idx stays 5, out_multi stays 1. Raise out_ready -> next cycle out_idx=7, out_multi=0.
5. Round-robin: mode=1, en=1, req=8'hFF held, out_ready=1 from reset -> out_idx sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles with out_valid continuously 1. The same stimulus in fixed mode -> 7 every cycle.
6. Reset mid-HOLD: in RR mode after grants 7,6, pull rst_n low asynchronously -> out_valid drops at once. After release with req=8'h11 -> first out_idx=4, confirming rr_ptr reset to 0.

Source files
------------

// File: rtl/prio_arb_pkg.sv
// Shared definitions for the priority/round-robin arbiter encoder:
// mode encodings, FSM state type and a clog2 helper.
package prio_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Ceiling log2; returns 1 for values <= 2 so index vectors are never zero-width.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 << result) < value) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/prio_enc_rot.sv
// Combinational rotating priority encoder: searches start-1, start-2, ... descending,
// wrapping modulo N, with start itself examined last.
module prio_enc_rot #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found,
  output logic             multi
);

  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  // Walk from lowest to highest priority so the last hit is the winner; index math wraps mod N.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand  = {IDX_W{1'b0}};
    idx   = {IDX_W{1'b0}};
    found = 1'b0;
    for (int k = N; k >= 1; k--) begin
      cand  = start - IDX_W'(k);
      idx   = req[cand] ? cand : idx;
      found = found | req[cand];
    end
  end

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign multi = |(req & (req - ONE_N));

endmodule

// File: rtl/prio_arb_encoder.sv
// Registered N-to-log2(N) priority encoder with fixed/round-robin arbitration
// and a valid/ready held result.
module prio_arb_encoder
  import prio_arb_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [N-1:0]     req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_grant,
  output logic             out_multi
);

  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic             valid_q;
  logic [IDX_W-1:0] idx_q;
  logic [N-1:0]     grant_q;
  logic             multi_q;

  logic [IDX_W-1:0] start_s;
  logic [IDX_W-1:0] enc_idx_s;
  logic             enc_found_s;
  logic             enc_multi_s;
  logic             cap_s;
  logic [N-1:0]     grant_d;

  // Fixed priority is the rotating search anchored at 0 (highest index first).
  assign start_s = (mode == MODE_FIXED) ? {IDX_W{1'b0}} : rr_ptr_q;

  prio_enc_rot #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_enc (
    .req   (req),
    .start (start_s),
    .idx   (enc_idx_s),
    .found (enc_found_s),
    .multi (enc_multi_s)
  );

  assign cap_s   = en && enc_found_s && ((state_q == ST_IDLE) || out_ready);
  assign grant_d = ONE_N << enc_idx_s;

  // Arbitration FSM: state, round-robin pointer and the held output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= {IDX_W{1'b0}};
      valid_q  <= 1'b0;
      idx_q    <= {IDX_W{1'b0}};
      grant_q  <= {N{1'b0}};
      multi_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (cap_s) begin
            state_q <= ST_HOLD;
            valid_q <= 1'b1;
            idx_q   <= enc_idx_s;
            grant_q <= grant_d;
            multi_q <= enc_multi_s;
            if (mode == MODE_RR) begin
              rr_ptr_q <= enc_idx_s;
            end
          end else if ((state_q == ST_HOLD) && out_ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            grant_q <= {N{1'b0}};
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          grant_q <= {N{1'b0}};
        end
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_grant = grant_q;
  assign out_multi = multi_q;

endmodule

// File: tb/tb_prio_arb_encoder.sv
// Self-checking bench for prio_arb_encoder (N=8): directed scenarios followed by
// random traffic, all checked against a behavioural model of the arbitration rules.
module tb_prio_arb_encoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [7:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] out_grant;
  logic       out_multi;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic m_valid;
  int   m_idx;
  logic m_multi;
  int   m_ptr;

  prio_arb_encoder #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_grant (out_grant),
    .out_multi (out_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int highest_set(input logic [7:0] r);
    int w;
    w = -1;
    for (int i = 0; i < 8; i++) if (r[i]) w = i;
    return w;
  endfunction

  function automatic int rr_pick(input logic [7:0] r, input int ptr);
    for (int k = 1; k <= 8; k++) begin
      int i;
      i = (ptr - k + 16) % 8;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_multi = 1'b0;
    m_ptr   = 0;
  endtask

  task automatic model_edge();
    logic cap;
    int   w;
    cap = en && (req != 8'h00) && (!m_valid || out_ready);
    if (cap) begin
      w       = mode ? rr_pick(req, m_ptr) : highest_set(req);
      m_valid = 1'b1;
      m_idx   = w;
      m_multi = ($countones(req) > 1);
      if (mode) m_ptr = w;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] eg;
    logic [2:0] ei;
    ei = 3'(m_idx);
    eg = m_valid ? (8'h01 << ei) : 8'h00;
    checks++;
    assert (out_valid === m_valid) else begin
      errors++;
      $error("FAIL %s valid: got %0b expected %0b", tag, out_valid, m_valid);
    end
    checks++;
    assert (out_idx === ei) else begin
      errors++;
      $error("FAIL %s idx: got %0d expected %0d", tag, out_idx, ei);
    end
    checks++;
    assert (out_grant === eg) else begin
      errors++;
      $error("FAIL %s grant: got %h expected %h", tag, out_grant, eg);
    end
    if (m_valid) begin
      checks++;
      assert (out_multi === m_multi) else begin
        errors++;
        $error("FAIL %s multi: got %0b expected %0b", tag, out_multi, m_multi);
      end
    end
  endtask

  task automatic chk_const(input string tag, input logic ev, input logic [2:0] ei);
    checks++;
    assert ((out_valid === ev) && (out_idx === ei)) else begin
      errors++;
      $error("FAIL %s: got valid=%0b idx=%0d expected valid=%0b idx=%0d",
             tag, out_valid, out_idx, ev, ei);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked before any clock edge.
  task automatic async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    assert ((out_valid === 1'b0) && (out_idx === 3'd0) && (out_grant === 8'h00) && (out_multi === 1'b0))
    else begin
      errors++;
      $error("FAIL %s: got valid=%0b idx=%0d grant=%h multi=%0b expected all zero",
             tag, out_valid, out_idx, out_grant, out_multi);
    end
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    mode      = 1'b0;
    req       = 8'h00;
    out_ready = 1'b0;
    model_reset();
    #2;
    check_model("reset_init");
    #10;
    rst_n = 1'b1;

    // Fixed mode basic capture, then release
    en = 1'b1; mode = 1'b0; req = 8'b0010_1100; out_ready = 1'b1;
    tick("fixed_cap");
    chk_const("fixed_cap_idx5", 1'b1, 3'd5);
    req = 8'h00;
    tick("fixed_release");
    chk_const("fixed_release_idle", 1'b0, 3'd5);

    // Enable gating
    en = 1'b0; req = 8'hFF;
    for (int i = 0; i < 10; i++) tick("en_gate");
    en = 1'b1;
    tick("en_on");
    chk_const("en_on_idx7", 1'b1, 3'd7);

    // Back-pressure
    req = 8'h00;
    tick("bp_drain");
    req = 8'b0010_1100; out_ready = 1'b0;
    tick("bp_cap");
    req = 8'h80;
    for (int i = 0; i < 4; i++) begin
      tick("bp_hold");
      chk_const("bp_hold_idx5", 1'b1, 3'd5);
    end
    out_ready = 1'b1;
    tick("bp_accept");
    chk_const("bp_accept_idx7", 1'b1, 3'd7);

    // Round-robin from reset: 7,6,...,0,7
    async_reset("reset_before_rr");
    mode = 1'b1; en = 1'b1; req = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      logic [2:0] e;
      e = 3'((7 - i + 8) % 8);
      tick("rr_seq");
      chk_const("rr_seq_const", 1'b1, e);
    end
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick("fixed_seq");
      chk_const("fixed_seq_idx7", 1'b1, 3'd7);
    end

    // Reset in the middle of HOLD clears rr_ptr
    async_reset("reset_before_rr2");
    mode = 1'b1;
    tick("rr2_a");
    tick("rr2_b");
    chk_const("rr2_b_idx6", 1'b1, 3'd6);
    req = 8'h11;
    async_reset("reset_mid_hold");
    tick("rr_after_reset");
    chk_const("rr_after_reset_idx4", 1'b1, 3'd4);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      req       = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      en        = ($urandom_range(0, 5) != 0);
      mode      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      if (i == 300) async_reset("reset_random");
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
